lsu_mem_initiator: RTL and testbench

- Initiator side of the core's single-port memory protocol (avalid/aready address phase, dvalid/dready read-data phase). It drives the memory responder on behalf of the load/store stage.
- Accepts one load/store request from the pipeline, issues the word-aligned access with the correct byte mask, and captures read data.
- Aligns and sign- or zero-extends load data, then returns a single response to the pipeline.
- Handles misalignment and responder timeout as error responses.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_mem_initiator_if.sv | 23 ++
 rtl/lsu_align.sv | 32 +++
 rtl/lsu_mem_initiator.sv | 143 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size 3 has no legal encoding, so it is reported through the same path.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] base_wmask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Single-port memory protocol: address phase (avalid/aready) and read-data phase (dvalid/dready).
interface lsu_mem_initiator_if;
  logic        avalid;
  logic        aready;
  logic [31:0] raddr;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        dvalid;
  logic        dready;

  modport master (
    output avalid, raddr, wen, waddr, wdata, wmask, dready,
    input  aready, rdata, dvalid
  );

  modport slave (
    input  avalid, raddr, wen, waddr, wdata, wmask, dready,
    output aready, rdata, dvalid
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data shift and load extract/extend. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata_lane,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  assign st_wmask      = base_wmask(st_size) << st_off;
  assign st_wdata_lane = st_wdata << {st_off, 3'b000};
  assign ld_shifted    = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: accepts one pipeline request, runs the memory access, returns one response.
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   ADDR  | avalid high, address-phase outputs held until aready or timeout
//   DATA  | dready high, waiting for read data or timeout
//   RESP  | resp_valid high, response held until resp_ready
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  lsu_mem_initiator_if.master mem
);

  // Counter value on the last permitted cycle in ADDR/DATA.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  lsu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]  l_size_q, l_off_q;
  logic        l_uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic        wen_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept, req_bad, afire, dfire, to_hit;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata, ld_data;

  lsu_align u_align (
    .st_size       (req_size),
    .st_off        (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_wmask      (st_wmask),
    .st_wdata_lane (st_wdata),
    .ld_size       (l_size_q),
    .ld_off        (l_off_q),
    .ld_unsigned   (l_uns_q),
    .ld_word       (mem.rdata),
    .ld_data       (ld_data)
  );

  assign accept  = (state_q == IDLE) && req_valid;
  assign req_bad = req_misaligned(req_size, req_addr[1:0]);
  assign afire   = (state_q == ADDR) && mem.aready;
  assign dfire   = (state_q == DATA) && mem.dvalid;
  assign to_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_bad ? RESP : ADDR;
      ADDR: begin
        if (afire)       state_d = wen_q ? RESP : DATA;
        else if (to_hit) state_d = RESP;
      end
      DATA: if (dfire || to_hit) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      l_size_q     <= '0;
      l_off_q      <= '0;
      l_uns_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_d != state_q) && ((state_d == ADDR) || (state_d == DATA)))
        cnt_q <= '0;
      else if ((state_q == ADDR) || (state_q == DATA))
        cnt_q <= cnt_q + CNT_W'(1);

      if (accept) begin
        l_size_q <= req_size;
        l_off_q  <= req_addr[1:0];
        l_uns_q  <= req_unsigned;
      end

      // Address-phase outputs live only while in ADDR so they read 0 elsewhere.
      if (accept && !req_bad) begin
        addr_q  <= {req_addr[31:2], 2'b00};
        wen_q   <= req_wen;
        wmask_q <= req_wen ? st_wmask : 4'b0000;
        wdata_q <= req_wen ? st_wdata : 32'h0;
      end else if ((state_q == ADDR) && (state_d != ADDR)) begin
        addr_q  <= '0;
        wen_q   <= 1'b0;
        wmask_q <= '0;
        wdata_q <= '0;
      end

      // Only a store address handshake or a read-data handshake count as success.
      if ((state_q != RESP) && (state_d == RESP)) begin
        resp_err_q   <= !(afire && wen_q) && !dfire;
        resp_rdata_q <= dfire ? ld_data : 32'h0;
      end else if ((state_q == RESP) && resp_ready) begin
        resp_err_q   <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign mem.avalid = (state_q == ADDR);
  assign mem.dready = (state_q == DATA);
  assign mem.raddr  = addr_q;
  assign mem.waddr  = addr_q;
  assign mem.wen    = wen_q;
  assign mem.wmask  = wmask_q;
  assign mem.wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed plus randomized bench for lsu_mem_initiator against an arithmetic reference model.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lsu_mem_initiator_if mem_if ();

  lsu_mem_initiator #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem          (mem_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit m_bad(input logic [1:0] sz, input logic [31:0] addr);
    int bytes;
    if (sz == 2'd3) return 1'b1;
    bytes = 1 << sz;
    return (addr % bytes) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input int off,
                                          input logic [1:0] sz, input bit uns);
    longint unsigned v, lim;
    int bits;
    bits = 8 * (1 << sz);
    v = longint'(word) / (longint'(1) << (8 * off));
    lim = longint'(1) << bits;
    v = v % lim;
    if (!uns && bits < 32 && v >= lim / 2) v = v + (longint'(1) << 32) - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] sz, input int off);
    int m;
    m = ((1 << (1 << sz)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int off);
    longint unsigned v;
    v = (longint'(wd) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
    return v[31:0];
  endfunction

  // One full request/response with aready after alat cycles and dvalid after dlat cycles.
  task automatic do_txn(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input bit uns, input logic [31:0] word,
                        input int alat, input int dlat);
    bit bad;
    int off, hold;
    logic [31:0] exp_rd;
    bad = m_bad(sz, addr);
    off = addr % 4;
    exp_rd = (bad || w) ? 32'h0 : m_load(word, off, sz, uns);

    req_valid = 1'b1; req_wen = w; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    @(negedge clock);
    check("req_ready_idle", {31'b0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;

    if (!bad) begin
      for (int k = 0; k <= alat; k++) begin
        mem_if.aready = (k == alat);
        mem_if.dvalid = 1'($urandom % 2);
        mem_if.rdata  = $urandom;
        @(negedge clock);
        check("avalid", {31'b0, mem_if.avalid}, 32'h1);
        check("raddr", mem_if.raddr, addr & 32'hFFFF_FFFC);
        check("waddr", mem_if.waddr, addr & 32'hFFFF_FFFC);
        check("wen", {31'b0, mem_if.wen}, {31'b0, w});
        check("wmask", {28'b0, mem_if.wmask}, w ? {28'b0, m_mask(sz, off)} : 32'h0);
        check("wdata", mem_if.wdata, w ? m_wdata(wd, off) : 32'h0);
        check("dready_addr", {31'b0, mem_if.dready}, 32'h0);
        tick();
      end
      mem_if.aready = 1'b0;
      mem_if.dvalid = 1'b0;
      if (!w) begin
        for (int k = 0; k <= dlat; k++) begin
          mem_if.dvalid = (k == dlat);
          mem_if.rdata  = (k == dlat) ? word : $urandom;
          @(negedge clock);
          check("dready", {31'b0, mem_if.dready}, 32'h1);
          check("avalid_data", {31'b0, mem_if.avalid}, 32'h0);
          tick();
        end
        mem_if.dvalid = 1'b0;
      end
    end

    hold = $urandom_range(0, 2);
    for (int h = 0; h <= hold; h++) begin
      resp_ready = (h == hold);
      mem_if.dvalid = 1'($urandom % 2);
      mem_if.rdata  = $urandom;
      @(negedge clock);
      check("resp_valid", {31'b0, resp_valid}, 32'h1);
      check("resp_err", {31'b0, resp_err}, {31'b0, bad});
      check("resp_rdata", resp_rdata, exp_rd);
      check("avalid_resp", {31'b0, mem_if.avalid}, 32'h0);
      check("dready_resp", {31'b0, mem_if.dready}, 32'h0);
      tick();
    end
    resp_ready = 1'b0;
    mem_if.dvalid = 1'b0;
    @(negedge clock);
    check("resp_done", {31'b0, resp_valid}, 32'h0);
    check("req_ready_back", {31'b0, req_ready}, 32'h1);
    tick();
  endtask

  // Load that never gets aready (phase 0) or never gets dvalid (phase 1).
  task automatic do_timeout(input bit data_phase);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = SZ_W;
    req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    if (data_phase) begin
      mem_if.aready = 1'b1;
      tick();
      mem_if.aready = 1'b0;
    end
    for (int k = 0; k < TO; k++) begin
      @(negedge clock);
      if (data_phase) check("to_dready_high", {31'b0, mem_if.dready}, 32'h1);
      else            check("to_avalid_high", {31'b0, mem_if.avalid}, 32'h1);
      tick();
    end
    @(negedge clock);
    check("to_avalid_low", {31'b0, mem_if.avalid}, 32'h0);
    check("to_dready_low", {31'b0, mem_if.dready}, 32'h0);
    check("to_resp_valid", {31'b0, resp_valid}, 32'h1);
    check("to_resp_err", {31'b0, resp_err}, 32'h1);
    check("to_resp_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b0;
    mem_if.aready = 1'b0; mem_if.dvalid = 1'b0; mem_if.rdata = '0;
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_avalid", {31'b0, mem_if.avalid}, 32'h0);
    check("rst_dready", {31'b0, mem_if.dready}, 32'h0);
    check("rst_raddr", mem_if.raddr, 32'h0);
    check("rst_wmask", {28'b0, mem_if.wmask}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    do_txn(1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b0, 32'h80FF_1234, 0, 1);
    do_txn(1'b0, 32'h8000_0002, 32'h0, SZ_H, 1'b1, 32'hBEEF_0000, 0, 0);
    do_txn(1'b0, 32'h8000_0002, 32'h0, SZ_H, 1'b0, 32'hBEEF_0000, 1, 2);
    do_txn(1'b1, 32'h8000_0001, 32'h0000_00AB, SZ_B, 1'b0, 32'h0, 3, 0);
    do_txn(1'b1, 32'h8000_0002, 32'h1234_5678, SZ_W, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 32'h8000_0001, 32'h0, SZ_H, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 32'h0, 0, 0);
    do_txn(1'b0, 32'h8000_0004, 32'h0, SZ_W, 1'b0, 32'hCAFE_F00D, TO - 1, TO - 1);

    do_timeout(1'b0);
    do_timeout(1'b1);

    // Async reset in the middle of a data phase.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000; req_size = SZ_W;
    tick();
    req_valid = 1'b0;
    mem_if.aready = 1'b1;
    tick();
    mem_if.aready = 1'b0;
    @(negedge clock);
    check("mid_dready", {31'b0, mem_if.dready}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_avalid", {31'b0, mem_if.avalid}, 32'h0);
    check("arst_dready", {31'b0, mem_if.dready}, 32'h0);
    check("arst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("arst_req_ready", {31'b0, req_ready}, 32'h1);
    #1 reset = 1'b0;
    tick();
    mem_if.dvalid = 1'b1; mem_if.rdata = 32'h1111_2222;
    tick();
    mem_if.dvalid = 1'b0;
    @(negedge clock);
    check("late_dvalid_resp", {31'b0, resp_valid}, 32'h0);
    check("late_dvalid_idle", {31'b0, req_ready}, 32'h1);
    tick();

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom;
      sz = 2'($urandom % 4);
      // Bias toward aligned addresses so most accesses reach the bus.
      if ($urandom % 4 != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
      do_txn(1'($urandom % 2), a, $urandom, sz, 1'($urandom % 2), $urandom,
             $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
